// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers,
// with frame locking, a start (busy) watchdog and a stalled-owner (hold) watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 64,
  parameter int HOLD_TIMEOUT = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_byte,
  output logic                 tx_en,
  input  logic                 tx_ready,
  output logic                 err_busy_to,
  output logic                 err_hold_to,
  output logic [1:0]           dbg_state
);

  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BCW = $clog2(BUSY_TIMEOUT + 1);
  localparam int HCW = $clog2(HOLD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_HOLD      = 2'd3
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_owner;
  logic             r_locked;
  logic [BCW-1:0]   r_busy_cnt;
  logic [HCW-1:0]   r_hold_cnt;

  logic             w_any;
  logic [IW-1:0]    w_winner;
  logic [IW-1:0]    w_scan;
  logic             w_idle_fire;
  logic             w_hold_fire;
  logic             w_fire;
  logic [IW-1:0]    w_sel;
  logic [7:0]       w_sel_byte;
  logic             w_sel_last;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(NUM_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // First valid requester at or above rr_ptr, wrapping.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_scan   = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && req_valid[w_scan]) begin
        w_any    = 1'b1;
        w_winner = w_scan;
      end
      w_scan = wrap_inc(w_scan);
    end
  end

  // Handshake: a byte moves on a clock edge where req_valid[i] && req_ready[i];
  // req_ready is only offered while the uart is idle, to the RR winner in IDLE
  // or to the locked owner in HOLD.
  assign w_idle_fire = (r_state == S_IDLE) && tx_ready && w_any;
  assign w_hold_fire = (r_state == S_HOLD) && tx_ready && req_valid[r_owner];
  assign w_fire      = w_idle_fire || w_hold_fire;
  assign w_sel       = (r_state == S_IDLE) ? w_winner : r_owner;

  always_comb begin
    req_ready  = '0;
    w_sel_byte = '0;
    w_sel_last = 1'b0;
    if (w_fire) req_ready[w_sel] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == IW'(i)) begin
        w_sel_byte = req_data[8*i +: 8];
        w_sel_last = req_last[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_locked    <= 1'b0;
      r_busy_cnt  <= '0;
      r_hold_cnt  <= '0;
      grant       <= '0;
      tx_byte     <= '0;
      tx_en       <= 1'b0;
      err_busy_to <= 1'b0;
      err_hold_to <= 1'b0;
    end else begin
      err_busy_to <= 1'b0;
      err_hold_to <= 1'b0;
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_fire) begin
            tx_byte    <= w_sel_byte;
            tx_en      <= 1'b1;
            grant      <= NUM_REQ'(1) << w_sel;
            r_owner    <= w_sel;
            r_locked   <= !w_sel_last;
            r_busy_cnt <= '0;
            r_hold_cnt <= '0;
            r_state    <= S_WAIT_BUSY;
          end else if (r_state == S_HOLD) begin
            // Only cycles with the owner's valid low count toward the stall limit.
            if (req_valid[r_owner]) begin
              r_hold_cnt <= '0;
            end else if (r_hold_cnt == HCW'(HOLD_TIMEOUT - 1)) begin
              err_hold_to <= 1'b1;
              grant       <= '0;
              r_locked    <= 1'b0;
              r_rr_ptr    <= wrap_inc(r_owner);
              r_hold_cnt  <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
        end
        S_WAIT_BUSY: begin
          if (!tx_ready) begin
            tx_en   <= 1'b0;
            r_state <= S_WAIT_DONE;
          end else if (r_busy_cnt == BCW'(BUSY_TIMEOUT - 1)) begin
            tx_en       <= 1'b0;
            err_busy_to <= 1'b1;
            r_locked    <= 1'b0;
            r_state     <= S_WAIT_DONE;
          end else begin
            r_busy_cnt <= r_busy_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (tx_ready) begin
            if (r_locked) begin
              r_hold_cnt <= '0;
              r_state    <= S_HOLD;
            end else begin
              grant    <= '0;
              r_rr_ptr <= wrap_inc(r_owner);
              r_state  <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = r_state;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between NUM_REQ byte producers, e.g. the CPU debug console, the loader echo and the status reporter.
- Arbitration is round-robin, with optional frame locking so a multi-byte message is never interleaved with another requester's bytes.
- The block drives the uart_tx tx_byte and tx_en inputs and monitors its tx_ready output.
- It flags a transmitter that never starts, and reclaims the grant from a requester that stalls mid-frame.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- BUSY_TIMEOUT, 64: maximum cycles to wait for tx_ready to fall after tx_en is raised.
- HOLD_TIMEOUT, 1000000: maximum cycles a locked owner may leave req_valid low before the lock is released.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i: requester i presents a byte.
- req_data  in  8*NUM_REQ  byte for requester i, in bits [8i+7:8i].
- req_last  in  NUM_REQ  bit i: the byte presented is the last of its frame.
- req_ready  out  NUM_REQ  combinational; a byte transfers in any cycle where req_valid[i] and req_ready[i] are both high.
- grant  out  NUM_REQ  registered, one-hot; identifies the current owner; all zeros when there is no owner.
- tx_byte  out  8  to uart_tx tx_byte.
- tx_en  out  1  to uart_tx tx_en.
- tx_ready  in  1  from uart_tx; high means idle and able to accept, low means shifting.
- err_busy_to  out  1  one-cycle pulse on BUSY_TIMEOUT expiry.
- err_hold_to  out  1  one-cycle pulse on HOLD_TIMEOUT expiry.

Behaviour:
- Reset values: state=IDLE, grant=0, tx_en=0, tx_byte=0, rr_ptr=0, locked=0, both error outputs=0, all counters=0.
- Reset asserted mid-transfer behaves the same way: tx_en drops and the arbiter ignores the byte still shifting out of uart_tx.
- req_ready is 0 for every requester outside the IDLE and HOLD accept conditions below.

IDLE state:
- If tx_ready=1 and any req_valid is high, the winner is the first valid index searching upward from rr_ptr, wrapping modulo NUM_REQ.
- req_ready[winner]=1 in that same cycle.
- On the next clock: tx_byte <= req_data[winner], tx_en <= 1, grant <= onehot(winner), locked <= !req_last[winner]. Go to WAIT_BUSY.
- If tx_ready=0, nothing is accepted.

WAIT_BUSY state:
- tx_en is held at 1.
- When tx_ready=0 is sampled: tx_en <= 0, go to WAIT_DONE.
- If the counter reaches BUSY_TIMEOUT first: tx_en <= 0, err_busy_to pulses, locked <= 0, go to WAIT_DONE.

WAIT_DONE state:
- When tx_ready=1:
  - If locked: go to HOLD.
  - Otherwise: grant <= 0, rr_ptr <= (owner+1) mod NUM_REQ, go to IDLE.

HOLD state:
- Only the owner may transfer; req_ready[owner] = req_valid[owner] && tx_ready.
- On a transfer: same capture as IDLE, locked <= !req_last[owner], go to WAIT_BUSY.
- The hold counter counts cycles with req_valid[owner]=0 and clears whenever req_valid[owner]=1.
- On reaching HOLD_TIMEOUT: err_hold_to pulses, grant <= 0, locked <= 0, rr_ptr <= owner+1, go to IDLE.
- Other requesters stall while HOLD is active.

Timing and data rules:
- Latency from the accept cycle to tx_en=1 is exactly 1 clock.
- At most one byte is ever outstanding.
- tx_byte is stable from capture until the next capture.
- Simultaneous requests are resolved by rr_ptr only; there is no fixed priority.
- A requester that drops req_valid in the accept cycle loses the slot.
- req_data is sampled only in the transfer cycle.

Test Plan:
1. Single byte, no lock: req_valid[0]=1, req_data=8'hAB, req_last=1, uart_tx model idle. Expect req_ready[0] high for 1 cycle, tx_en high the next cycle, tx_byte=8'hAB, grant=4'b0001 until tx_ready returns high, then grant=0 and rr_ptr=1.
2. Round-robin: all four requesters valid with bytes 8'h10..8'h13, all with req_last=1, held valid for four bytes. Expect tx_byte order 10, 11, 12, 13, 10..., with no requester serviced twice in succession.
3. Frame lock: requester 2 sends 8'hFF, 8'h00, 8'h12 with req_last only on 8'h12, while requester 1 is constantly valid. Expect all three bytes from requester 2 back-to-back, then requester 3 (if valid) or wrap to requester 1, with grant=4'b0100 throughout the frame.
4. Busy timeout: tx_ready held at 1 permanently. Expect tx_en high for exactly BUSY_TIMEOUT cycles, one err_busy_to pulse, tx_en back to 0, and the arbiter back in IDLE with grant=0.
5. Hold timeout (HOLD_TIMEOUT set to 20): owner sends one non-last byte, then drops req_valid. Expect err_hold_to at cycle 20 of inactivity, grant=0, and the next requester then served.
6. Reset mid-frame: assert rst for 1 cycle during WAIT_BUSY of a locked frame. Expect tx_en=0, grant=0, no error pulses, and the next request served from index 0.
